// File: rtl/mem_access_ctrl_if.sv
// Bus-side bundle of the load/store access controller.
// master = access controller, slave = memory/bus fabric.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                bus_req;
  logic                bus_wr;
  logic [31:0]         bus_addr;
  logic [DATA_W/8-1:0] bus_wstrb;
  logic [DATA_W-1:0]   bus_wdata;
  logic                bus_addr_ok;
  logic                bus_data_ok;
  logic [DATA_W-1:0]   bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_addr,
    output bus_wstrb, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr,
    input  bus_wstrb, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: alignment check, bus
// handshake FSM with flush drain, timeout and load extension.
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_addr,
  output logic        bus_err,
  mem_access_ctrl_if.master bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DRAIN
  } state_t;

  state_t state, state_nx;

  logic             is_ld, is_st, mis;
  logic [1:0]       sz;
  logic             acc, busy, fin, to_hit;
  logic [15:0]      cnt, cnt_inc;
  logic [5:0]       op_q;
  logic [OFF_W-1:0] off, off_q;
  logic [NB-1:0]    strb;
  logic [DATA_W-1:0] wlane;
  logic [OFF_W+2:0] bo;
  logic [7:0]       lb;
  logic [15:0]      lh;
  logic [31:0]      lw, ld_val;

  // sz: 0 byte, 1 half, 2 word
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sz    = 2'd0;
    unique case (op)
      OP_LB, OP_LBU: is_ld = 1'b1;
      OP_LH, OP_LHU: begin
        is_ld = 1'b1;
        sz    = 2'd1;
      end
      OP_LW: begin
        is_ld = 1'b1;
        sz    = 2'd2;
      end
      OP_SB: is_st = 1'b1;
      OP_SH: begin
        is_st = 1'b1;
        sz    = 2'd1;
      end
      OP_SW: begin
        is_st = 1'b1;
        sz    = 2'd2;
      end
      default: ;
    endcase
  end

  assign mis = (sz == 2'd1 && addr[0]) ||
               (sz == 2'd2 && addr[1:0] != 2'b00);
  assign adel     = is_ld & mis;
  assign ades     = is_st & mis;
  assign bad_addr = (adel | ades) ? addr : pc;

  // done still shows the held request; it must not re-issue
  assign busy    = state != IDLE;
  assign acc     = !busy && req_valid && (is_ld || is_st) &&
                   !mis && !flush && !done;
  assign stall   = acc || busy;
  assign cnt_inc = cnt + 16'd1;

  assign off = addr[OFF_W-1:0];

  always_comb begin
    strb  = '0;
    wlane = {(DATA_W/32){wdata}};
    unique case (sz)
      2'd0: begin
        strb  = NB'(1) << off;
        wlane = {NB{wdata[7:0]}};
      end
      2'd1: begin
        strb  = NB'(3) << off;
        wlane = {(NB/2){wdata[15:0]}};
      end
      default: strb = NB'(15) << off;
    endcase
    if (!is_st) strb = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fin      = 1'b0;
    to_hit   = 1'b0;
    unique case (state)
      IDLE: if (acc) state_nx = REQ;
      REQ: begin
        if (flush)
          state_nx = (bus.bus_addr_ok && !bus.bus_data_ok) ?
                     DRAIN : IDLE;
        else if (bus.bus_addr_ok && bus.bus_data_ok) begin
          state_nx = IDLE;
          fin      = 1'b1;
        end else if (bus.bus_addr_ok)
          state_nx = WAIT;
      end
      WAIT: begin
        if (bus.bus_data_ok) begin
          state_nx = IDLE;
          fin      = !flush;
        end else if (flush)
          state_nx = DRAIN;
      end
      DRAIN: if (bus.bus_data_ok) state_nx = IDLE;
    endcase
    // a completion or flush on the last allowed cycle wins
    if (busy && state_nx != IDLE && cnt_inc == TO) begin
      state_nx = IDLE;
      to_hit   = 1'b1;
    end
  end

  assign bo = {off_q, 3'b000};
  assign lb = bus.bus_rdata[bo +: 8];
  assign lh = bus.bus_rdata[bo +: 16];
  assign lw = bus.bus_rdata[bo +: 32];

  always_comb begin
    unique case (op_q)
      OP_LB:   ld_val = {{24{lb[7]}}, lb};
      OP_LBU:  ld_val = {24'd0, lb};
      OP_LH:   ld_val = {{16{lh[15]}}, lh};
      OP_LHU:  ld_val = {16'd0, lh};
      default: ld_val = lw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      rdata         <= '0;
      done          <= 1'b0;
      bus_err       <= 1'b0;
      op_q          <= '0;
      off_q         <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_wr    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wstrb <= '0;
      bus.bus_wdata <= '0;
    end else begin
      done        <= fin;
      bus_err     <= to_hit;
      bus.bus_req <= state_nx == REQ;
      if (fin) rdata <= ld_val;
      if (acc) begin
        cnt           <= '0;
        op_q          <= op;
        off_q         <= off;
        bus.bus_addr  <= {addr[31:OFF_W], {OFF_W{1'b0}}};
        bus.bus_wr    <= is_st;
        bus.bus_wstrb <= strb;
        bus.bus_wdata <= wlane;
      end else if (busy) begin
        cnt <= cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Random + directed bench for mem_access_ctrl, 32- and
// 64-bit instances driven in lockstep against a txn model.
module tb_mem_access_ctrl;
  localparam int TO = 4;
  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;
  localparam int K_DONE = 0, K_FLUSH = 1;
  localparam int K_DRAIN = 2, K_TMO = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0, pc = '0;

  logic        stall32, done32, adel32, ades32, err32;
  logic [31:0] rdata32, bad32;
  logic        stall64, done64, adel64, ades64, err64;
  logic [31:0] rdata64, bad64;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp32 = '0, exp64 = '0;
  logic [5:0]  mops [8] = '{LB, LBU, LH, LHU, LW, SB, SH, SW};

  mem_access_ctrl_if #(.DATA_W(32)) bi32 ();
  mem_access_ctrl_if #(.DATA_W(64)) bi64 ();

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(32), .TIMEOUT(TO)) u32 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .op(op), .addr(addr), .wdata(wdata), .pc(pc),
    .flush(flush), .stall(stall32), .rdata(rdata32),
    .done(done32), .adel(adel32), .ades(ades32),
    .bad_addr(bad32), .bus_err(err32), .bus(bi32.master)
  );

  mem_access_ctrl #(.DATA_W(64), .TIMEOUT(TO)) u64 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .op(op), .addr(addr), .wdata(wdata), .pc(pc),
    .flush(flush), .stall(stall64), .rdata(rdata64),
    .done(done64), .adel(adel64), .ades(ades64),
    .bad_addr(bad64), .bus_err(err64), .bus(bi64.master)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic bus_in(input logic aok, input logic dok);
    bi32.bus_addr_ok = aok;
    bi64.bus_addr_ok = aok;
    bi32.bus_data_ok = dok;
    bi64.bus_data_ok = dok;
  endtask

  function automatic bit is_load(input logic [5:0] o);
    return o inside {LB, LBU, LH, LHU, LW};
  endfunction

  function automatic bit is_store(input logic [5:0] o);
    return o inside {SB, SH, SW};
  endfunction

  function automatic int size_of(input logic [5:0] o);
    if (o == LB || o == LBU || o == SB) return 1;
    if (o == LH || o == LHU || o == SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_ref(
    input logic [5:0] o, input logic [31:0] a,
    input logic [63:0] rd, input int dw);
    logic [63:0] v;
    int off;
    off = int'(a[2:0]) % (dw / 8);
    v = (dw == 32) ? {32'd0, rd[31:0]} : rd;
    v = v >> (8 * off);
    case (o)
      LB:  return v[7] ? 32'(v[7:0]) - 32'd256 : 32'(v[7:0]);
      LH:  return v[15] ? 32'(v[15:0]) - 32'h10000
                        : 32'(v[15:0]);
      LBU: return 32'(v[7:0]);
      LHU: return 32'(v[15:0]);
      default: return v[31:0];
    endcase
  endfunction

  function automatic logic [7:0] strb_ref(
    input logic [5:0] o, input logic [31:0] a, input int dw);
    int off;
    if (!is_store(o)) return 8'd0;
    off = int'(a[2:0]) % (dw / 8);
    return 8'(((1 << size_of(o)) - 1) << off);
  endfunction

  function automatic logic [63:0] wd_ref(
    input logic [5:0] o, input logic [31:0] w, input int dw);
    logic [63:0] r;
    int sz;
    r  = '0;
    sz = size_of(o);
    for (int i = 0; i < dw / 8; i++)
      r[8*i +: 8] = w[8*(i % sz) +: 8];
    return r;
  endfunction

  // One pipeline request; a/d/f = cycle (after accept) of
  // addr_ok, data_ok and flush pulses (f=0: no flush).
  task automatic txn(input logic [5:0] o, input logic [31:0] ad,
                     input logic [31:0] wd, input logic [63:0] rd,
                     input int a, input int d, input int f);
    bit ld, st, mis, go;
    int e, kind, rq;
    logic [31:0] pcv;
    ld  = is_load(o);
    st  = is_store(o);
    mis = (ld || st) && (ad % size_of(o) != 0);
    go  = (ld || st) && !mis;
    pcv = $urandom;
    @(negedge clk);
    req_valid = 1'b1;
    op = o; addr = ad; wdata = wd; pc = pcv; flush = 1'b0;
    bus_in(1'b0, 1'b0);
    bi32.bus_rdata = rd[31:0];
    bi64.bus_rdata = rd;
    #1;
    chk("adel", adel32, ld && mis);
    chk("ades", ades32, st && mis);
    chk("bad_addr", bad32, mis ? ad : pcv);
    chk("adel64", adel64, ld && mis);
    chk("bad_addr64", bad64, mis ? ad : pcv);
    chk("stall_acc", stall32, go);
    chk("stall_acc64", stall64, go);
    if (!go) begin
      @(negedge clk); #1;
      chk("nomem_req", bi32.bus_req, 0);
      chk("nomem_req64", bi64.bus_req, 0);
      chk("nomem_stall", stall32, 0);
      chk("nomem_done", done32, 0);
      return;
    end
    if (f != 0 && f < a) begin
      e = f; kind = K_FLUSH;
    end else begin
      e = d;
      kind = (f != 0 && f <= d) ? K_DRAIN : K_DONE;
    end
    if (e > TO) begin
      e = TO; kind = K_TMO;
    end
    rq = (a < e) ? a : e;
    for (int k = 1; k <= e + 1; k++) begin
      @(negedge clk);
      req_valid = (k <= e) || kind == K_DONE;
      bus_in(k == a, k == d);
      flush = (k == f);
      #1;
      chk("stall", stall32, k <= e);
      chk("stall64", stall64, k <= e);
      chk("bus_req", bi32.bus_req, k <= rq);
      chk("bus_req64", bi64.bus_req, k <= rq);
      chk("done", done32, k == e + 1 && kind == K_DONE);
      chk("done64", done64, k == e + 1 && kind == K_DONE);
      chk("bus_err", err32, k == e + 1 && kind == K_TMO);
      chk("bus_err64", err64, k == e + 1 && kind == K_TMO);
      if (k == 1) begin
        chk("bus_addr", bi32.bus_addr, ad & ~32'd3);
        chk("bus_addr64", bi64.bus_addr, ad & ~32'd7);
        chk("bus_wr", bi32.bus_wr, st);
        chk("bus_wstrb", bi32.bus_wstrb, strb_ref(o, ad, 32));
        chk("bus_wstrb64", bi64.bus_wstrb, strb_ref(o, ad, 64));
        if (st) begin
          chk("bus_wdata", bi32.bus_wdata, wd_ref(o, wd, 32));
          chk("bus_wdata64", bi64.bus_wdata, wd_ref(o, wd, 64));
        end
      end
      if (k == e + 1) begin
        if (kind == K_DONE) begin
          exp32 = load_ref(o, ad, rd, 32);
          exp64 = load_ref(o, ad, rd, 64);
        end
        if (ld || kind == K_DONE) begin
          chk("rdata", rdata32, exp32);
          chk("rdata64", rdata64, exp64);
        end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus_in(1'b0, 1'b0);
    bi32.bus_rdata = '0;
    bi64.bus_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", stall32, 0);
    chk("rst_done", done32, 0);
    chk("rst_rdata", rdata32, 0);
    chk("rst_rdata64", rdata64, 0);
    chk("rst_bus_req", bi32.bus_req, 0);
    chk("rst_bus_err", err64, 0);
    chk("rst_bus_addr", bi64.bus_addr, 0);
    chk("rst_wstrb", bi64.bus_wstrb, 0);

    txn(LB, 32'h1003, 32'h0, 64'h0000_0000_80FF_0000, 1, 3, 0);
    chk("lb_sext", rdata32, 32'hFFFF_FF80);
    txn(SH, 32'h2002, 32'h0000_ABCD, 64'h0, 1, 1, 0);
    chk("sh_strb", bi32.bus_wstrb, 4'b1100);
    chk("sh_wdata", bi32.bus_wdata, 32'hABCD_ABCD);
    chk("sh_wr", bi32.bus_wr, 1);
    txn(SH, 32'h2006, 32'h0000_ABCD, 64'h0, 1, 2, 0);
    chk("sh64_strb", bi64.bus_wstrb, 8'hC0);
    chk("sh64_addr", bi64.bus_addr, 32'h2000);
    txn(LW, 32'h1002, 32'h0, 64'h0, 1, 1, 0);
    chk("lw_adel", adel32, 1);
    chk("lw_bad", bad32, 32'h1002);
    txn(LW, 32'h3000, 32'h0, 64'h1234_5678_9ABC_DEF0, 1, 4, 2);
    txn(LHU, 32'h3006, 32'h0, 64'hFEDC_BA98_7654_3210, 2, 2, 0);
    txn(LW, 32'h4000, 32'h0, 64'h0, 9, 9, 0);
    chk("tmo_err", err32, 1);

    // reset while the access waits for data
    @(negedge clk);
    req_valid = 1'b1; op = LW; addr = 32'h5000; flush = 1'b0;
    bus_in(1'b0, 1'b0);
    #1;
    chk("rm_acc", stall32, 1);
    @(negedge clk);
    bus_in(1'b1, 1'b0);
    #1;
    chk("rm_req", bi32.bus_req, 1);
    @(negedge clk);
    bus_in(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rm_wait", stall64, 1);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    bus_in(1'b0, 1'b1);
    #1;
    chk("rm_stall", stall32, 0);
    chk("rm_stall64", stall64, 0);
    chk("rm_done", done32, 0);
    chk("rm_rdata", rdata32, 0);
    chk("rm_bus_req", bi32.bus_req, 0);
    chk("rm_bus_addr", bi32.bus_addr, 0);
    chk("rm_wdata", bi32.bus_wdata, 0);
    chk("rm_bus_err", err32, 0);
    @(negedge clk);
    bus_in(1'b0, 1'b0);
    #1;
    chk("rm_late_done", done32, 0);
    chk("rm_late_done64", done64, 0);
    exp32 = '0;
    exp64 = '0;

    for (int n = 0; n < 120; n++) begin
      logic [5:0]  o;
      logic [31:0] ad;
      logic [63:0] rd;
      int a, d, f;
      if ($urandom_range(0, 9) == 0)
        o = 6'($urandom_range(0, 31));
      else
        o = mops[$urandom_range(0, 7)];
      ad = $urandom;
      if ($urandom_range(0, 9) < 7)
        ad = ad & ~(32'(size_of(o)) - 32'd1);
      rd = {$urandom, $urandom};
      a  = $urandom_range(1, 3);
      d  = a + $urandom_range(0, 2);
      f  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d + 1)
                                       : 0;
      if (f == d) f = 0;
      txn(o, ad, $urandom, rd, a, d, f);
    end

    @(negedge clk);
    req_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
